uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmitter. It serialises one word per valid/ready handshake onto tx, LSB first.
//  The frame format is set at elaboration: data width, optional odd/even parity, and 1 or 2 stop bits.
//  Frames stream back-to-back with no idle gap while in_valid stays high.
//  It sits between the text/RAM sequencer and the board uart_rx_out pin.
// PARAMETERS
//  CLK_FREQ   100000000  input clock frequency, Hz
//  BAUD       115200     line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer, truncated)
//  DATA_BITS  8          data bits per frame, legal range 5..9
//  PARITY     0          0 = none, 1 = odd, 2 = even
//  STOP_BITS  1          1 or 2
// PORTS
//  clk         in   1          system clock, rising edge
//  rst_n       in   1          asynchronous reset, active low
//  in_valid    in   1          input_data holds a word to send
//  in_ready    out  1          block accepts a word on this cycle
//  input_data  in   DATA_BITS  word to send; sampled only on the accept cycle
//  busy        out  1          a frame is being driven on tx
//  tx          out  1          serial line; idles high
// BEHAVIOUR
//  Reset
//   - Applying reset immediately forces: tx=1, busy=0, in_ready=0, state=IDLE.
//   - In-flight frame is dropped.
//   - in_ready rises at the first clk edge after rst_n goes high.
//  Outputs
//   - tx, busy and in_ready are registered; no combinational path from the inputs.
//  Accept
//   - A word is accepted when in_valid && in_ready on a rising edge.
//   - The word is latched into an internal shift register; later changes to input_data are ignored.
//   - in_valid while in_ready=0 is ignored; the word is not queued.
//  State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START
//   - IDLE: tx=1, busy=0, in_ready=1. On accept, go to START.
//   - START: tx=0.
//   - DATA: DATA_BITS bits, LSB first; a bit index counts 0..DATA_BITS-1.
//   - PARITY: present only if PARITY!=0. Bit = ^data for even, ~^data for odd, so that the
//     data+parity ones count comes out even or odd respectively.
//   - STOP: STOP_BITS bits, each tx=1.
//  Latency and timing
//   - tx shows the start bit on the cycle after the accept edge.
//   - Every bit is held exactly CLKS_PER_BIT cycles.
//   - Bit-cycle counter width is $clog2(CLKS_PER_BIT). It reloads at CLKS_PER_BIT-1 and counts down to 0.
//   - Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
//  Gapless streaming
//   - in_ready is also 1 during the final cycle of the last stop bit.
//   - An accept there goes straight to START, so the next start bit directly follows the stop bit.
//   - With no accept there, go to IDLE.
//  busy
//   - 1 from the START cycle through the last stop cycle.
//   - Stays 1 across a gapless frame boundary.
//  Illegal parameters
//   - DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1..2, or CLKS_PER_BIT<2 -> $error at elaboration.
// TESTING
//  Bench config: CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10).
//  1. Reset release, 8N1: in_valid=1, input_data=0x55 ->
//     - tx bits 0,1,0,1,0,1,0,1,0,1, each 10 cycles; 100-cycle frame.
//     - busy=1 for exactly 100 cycles, then tx=1, in_ready=1.
//  2. PARITY=2, 8E1, input_data=0x07 -> parity bit 1; frame 110 cycles.
//     PARITY=1, 8O1, 0x03 -> parity bit 1. PARITY=1, 0x07 -> parity bit 0.
//  3. Back-to-back: in_valid held, 0xA5 then 0x3C ->
//     - second start-bit falling edge exactly 100 cycles after the first.
//     - busy never drops between frames; in_ready high for one cycle per frame.
//  4. DATA_BITS=5, STOP_BITS=2, input_data=0x1F (0xFF on the wider bus, upper bits unused) ->
//     - 0, 1x5, 1x2; 80-cycle frame.
//  5. Reset mid-frame: assert rst_n=0 at cycle 35 of the 0x55 frame ->
//     - tx=1 and busy=0 before the next edge.
//     - After release: in_ready=1 one cycle later; the next frame sends the new word, not 0x55.
//  6. input_data changed and in_valid pulsed during a frame -> transmitted bits unchanged; no extra frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, sent LSB first with elaboration-time
// data width, parity and stop-bit count. Frames stream back-to-back while in_valid stays high.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] input_data,
  output logic                 busy,
  output logic                 tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = (STOP_BITS == 2);
  localparam bit               HAS_PARITY = (PARITY != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_param_check
    $error("uart_tx_frame: illegal parameters DATA_BITS=%0d PARITY=%0d STOP_BITS=%0d CLKS_PER_BIT=%0d",
           DATA_BITS, PARITY, STOP_BITS, CLKS_PER_BIT);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_d, busy_d, ready_d;
  logic                 accept, bit_done, frame_end, load;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    accept    = in_valid && in_ready;
    bit_done  = (cnt_q == '0);
    frame_end = (state_q == S_STOP) && bit_done && (stop_q == LAST_STOP);
    load      = accept && ((state_q == S_IDLE) || frame_end);

    case (state_q)
      S_IDLE: ;
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          cnt_d   = CNT_MAX;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = CNT_MAX;
          if (idx_q == LAST_IDX) begin
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          cnt_d   = CNT_MAX;
          stop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (stop_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = CNT_MAX;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accept in the last stop cycle overrides the drop to IDLE: gapless next frame.
    if (load) begin
      state_d = S_START;
      cnt_d   = CNT_MAX;
      shreg_d = input_data;
      par_d   = (PARITY == 2) ? ^input_data : ~^input_data;
    end

    // Outputs are computed from the next state so they can be registered without lag.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) ||
              ((state_d == S_STOP) && (stop_d == LAST_STOP) && (cnt_d == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx       <= tx_d;
      busy     <= busy_d;
      in_ready <= ready_d;
    end
  end

  // NOTE: the payload registers are always loaded before they reach tx, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four frame formats at 10 clocks per bit, a frame-position model
// compared every cycle, plus directed frames with hand-computed expectations.
module tb_uart_tx_frame;

  localparam int CPB = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid [4];
  logic [8:0] din      [4];
  wire  [3:0] tx_all, busy_all, rdy_all;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // cfg0 8N1, cfg1 8E1, cfg2 8O1, cfg3 5N2
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DB   = (g == 3) ? 5 : 8;
    localparam int PAR  = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB   = (g == 3) ? 2 : 1;
    localparam int FLEN = CPB * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

    uart_tx_frame #(
      .CLK_FREQ (1000000),
      .BAUD     (100000),
      .DATA_BITS(DB),
      .PARITY   (PAR),
      .STOP_BITS(SB)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (rdy_all[g]),
      .input_data(din[g][DB-1:0]),
      .busy      (busy_all[g]),
      .tx        (tx_all[g])
    );

    // Bit k of the result is the k-th bit on the line; anything past parity is stop (1).
    function automatic logic [15:0] frame_of(input logic [8:0] d);
      logic [15:0] f;
      int ones;
      f    = '1;
      ones = 0;
      f[0] = 1'b0;
      for (int k = 0; k < DB; k++) begin
        f[1 + k] = d[k];
        if (d[k]) ones++;
      end
      if (PAR == 2) f[1 + DB] = (ones % 2 == 1);
      if (PAR == 1) f[1 + DB] = (ones % 2 == 0);
      return f;
    endfunction

    logic [15:0] m_bits   = '1;
    int          m_pos    = 0;
    logic        m_active = 1'b0;
    logic        m_armed  = 1'b0;
    logic        m_rdy_now;
    logic        exp_tx;

    assign m_rdy_now = m_active ? (m_pos == FLEN - 1) : m_armed;
    assign exp_tx    = m_active ? m_bits[m_pos / CPB] : 1'b1;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_active <= 1'b0;
        m_armed  <= 1'b0;
        m_pos    <= 0;
      end else begin
        m_armed <= 1'b1;
        if (in_valid[g] && m_rdy_now) begin
          m_bits   <= frame_of(din[g]);
          m_pos    <= 0;
          m_active <= 1'b1;
        end else if (m_active) begin
          if (m_pos == FLEN - 1) m_active <= 1'b0;
          else m_pos <= m_pos + 1;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("cfg%0d tx", g), int'(tx_all[g]), int'(exp_tx));
      check($sformatf("cfg%0d busy", g), int'(busy_all[g]), int'(m_active));
      check($sformatf("cfg%0d in_ready", g), int'(rdy_all[g]), int'(m_rdy_now));
    end
  end

  task automatic send(input int g, input logic [8:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    din[g]      = d;
    in_valid[g] = 1'b1;
    while (!rdy_all[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("cfg%0d accept_wait", g), int'(n < 500), 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid[g] = 1'b0;
  endtask

  // Sample i is taken between accept-edge+i and accept-edge+i+1.
  task automatic capture(input int g, input int n,
                         output logic [255:0] txv, output logic [255:0] bsv,
                         output logic [255:0] rdv);
    txv = '0;
    bsv = '0;
    rdv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txv[i] = tx_all[g];
      bsv[i] = busy_all[g];
      rdv[i] = rdy_all[g];
    end
  endtask

  // Mid-bit samples of nb consecutive line bits, starting at sample offset off.
  function automatic int bits_at(input logic [255:0] v, input int off, input int nb);
    int r;
    r = 0;
    for (int k = 0; k < nb; k++) if (v[off + CPB * k + CPB / 2]) r += (1 << k);
    return r;
  endfunction

  function automatic int ones_in(input logic [255:0] v, input int n);
    int r;
    r = 0;
    for (int i = 0; i < n; i++) if (v[i]) r++;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] tv, bv, rv;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      din[i]      = '0;
    end

    // Reset state and in_ready rising one edge after release
    #1 rst_n = 1'b0;
    #2;
    check("reset tx", int'(tx_all[0]), 1);
    check("reset busy", int'(busy_all[0]), 0);
    check("reset in_ready", int'(rdy_all[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("release in_ready low", int'(rdy_all[0]), 0);
    @(negedge clk);
    check("release in_ready after edge", int'(rdy_all[0]), 1);

    // 8N1, 0x55
    send(0, 9'h055, 1'b0);
    capture(0, 110, tv, bv, rv);
    check("8N1 0x55 line bits", bits_at(tv, 0, 10), 'h2AA);
    check("8N1 busy cycles", ones_in(bv, 110), 100);
    check("8N1 tx after frame", int'(tv[100]), 1);
    check("8N1 in_ready after frame", int'(rv[100]), 1);

    // Parity variants
    send(1, 9'h007, 1'b0);
    capture(1, 120, tv, bv, rv);
    check("8E1 0x07 data", bits_at(tv, CPB, 8), 'h07);
    check("8E1 0x07 parity", int'(tv[95]), 1);
    check("8E1 busy cycles", ones_in(bv, 120), 110);
    send(2, 9'h003, 1'b0);
    capture(2, 120, tv, bv, rv);
    check("8O1 0x03 parity", int'(tv[95]), 1);
    send(2, 9'h007, 1'b0);
    capture(2, 120, tv, bv, rv);
    check("8O1 0x07 parity", int'(tv[95]), 0);
    check("8O1 stop bit", int'(tv[105]), 1);

    // Back-to-back with in_valid held
    send(0, 9'h0A5, 1'b1);
    din[0] = 9'h03C;
    capture(0, 200, tv, bv, rv);
    in_valid[0] = 1'b0;
    check("b2b first data", bits_at(tv, CPB, 8), 'hA5);
    check("b2b stop before second start", int'(tv[99]), 1);
    check("b2b second start at +100", int'(tv[100]), 0);
    check("b2b second data", bits_at(tv, 100 + CPB, 8), 'h3C);
    check("b2b busy never drops", ones_in(bv, 200), 200);
    check("b2b in_ready cycles", ones_in(rv, 200), 2);

    // 5N2 with upper bus bits set
    send(3, 9'h0FF, 1'b0);
    capture(3, 90, tv, bv, rv);
    check("5N2 line bits", bits_at(tv, 0, 8), 'hFE);
    check("5N2 busy cycles", ones_in(bv, 90), 80);
    check("5N2 idle after", int'(bv[80]), 0);

    // Reset in the middle of a frame
    send(0, 9'h055, 1'b0);
    capture(0, 35, tv, bv, rv);
    check("midreset busy before", int'(bv[34]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset tx forced", int'(tx_all[0]), 1);
    check("midreset busy forced", int'(busy_all[0]), 0);
    check("midreset in_ready forced", int'(rdy_all[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midreset release in_ready low", int'(rdy_all[0]), 0);
    @(negedge clk);
    check("midreset in_ready one cycle later", int'(rdy_all[0]), 1);
    send(0, 9'h00F, 1'b0);
    capture(0, 110, tv, bv, rv);
    check("post-reset new word", bits_at(tv, CPB, 8), 'h0F);
    check("post-reset busy cycles", ones_in(bv, 110), 100);

    // Input changes and a stray in_valid pulse during a frame are ignored
    send(0, 9'h0C3, 1'b0);
    fork
      capture(0, 150, tv, bv, rv);
      begin
        repeat (30) @(negedge clk);
        din[0]      = 9'h000;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
      end
    join
    check("ignore data unchanged", bits_at(tv, CPB, 8), 'hC3);
    check("ignore no extra frame", ones_in(bv, 150), 100);
    check("ignore in_ready cycles", ones_in(rv, 150), 51);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
